// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer with a 2-bit saturating direction counter
// per entry. The fetch PC is looked up combinationally to produce the
// next-PC prediction. Resolved conditional branches coming back from exec
// update the table on the next rising edge. The same resolution inputs also
// produce a combinational mispredict/flush request and the corrected PC.
//
// Optional feature macro: BP_STATS_EN
//   When defined, adds two saturating 32-bit statistics counters:
//   resolved branches and mispredicts.
//   Predictor behaviour is the same with or without the macro.
//
// Ports
//   CLK             in   1   clock, rising edge
//   nRST            in   1   asynchronous active-low reset
//   fetch_pc        in   32  PC of the instruction in fetch
//   pred_taken      out  1   predicted direction for fetch_pc
//   pred_target     out  32  predicted next PC (target or fetch_pc + 4)
//   upd_en          in   1   a conditional branch resolved this cycle
//   upd_pc          in   32  PC of the resolved branch
//   upd_taken       in   1   actual outcome
//   upd_target      in   32  actual branch target
//   upd_pred_taken  in   1   direction that was predicted for it
//   upd_pred_target in   32  next PC that was predicted for it
//   mispredict      out  1   flush request (combinational from upd_*)
//   redirect_pc     out  32  corrected next PC, 0 when upd_en = 0
//   hit             out  1   fetch_pc matched a valid entry
//   stat_branches   out  32  (BP_STATS_EN only) resolved branch count
//   stat_mispred    out  32  (BP_STATS_EN only) mispredict count
// ----------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic        hit
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
`endif
);

    localparam int TAG_W = 32 - IDX_W - 2;

    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    // Instructions are word aligned; the low PC bits carry no information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign fetch_tag = fetch_pc[31:IDX_W+2];
    assign upd_idx   = upd_pc[IDX_W+1:2];
    assign upd_tag   = upd_pc[31:IDX_W+2];

    // Lookup reads the registered table only, so an update to the same
    // index in this cycle is seen by fetch one cycle later.
    assign hit         = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign pred_taken  = hit && ctr_q[fetch_idx][1];
    assign pred_target = pred_taken ? tgt_q[fetch_idx] : fetch_pc + 32'd4;

    // A correct "taken" direction can still redirect if the target differs.
    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = 32'd0;
        if (upd_en) begin
            mispredict  = (upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_target != upd_pred_target));
            redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;
        end
    end

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int e = 0; e < ENTRIES; e++) begin
                valid_q[e] <= 1'b0;
                tag_q[e]   <= '0;
                tgt_q[e]   <= '0;
                ctr_q[e]   <= CTR_WNT;
            end
        end else if (upd_en) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    ctr_q[upd_idx] <= ctr_inc(ctr_q[upd_idx]);
                    tgt_q[upd_idx] <= upd_target;
                end else begin
                    ctr_q[upd_idx] <= ctr_dec(ctr_q[upd_idx]);
                end
            end else if (upd_taken) begin
                // Allocation overwrites whatever branch aliased into this slot.
                valid_q[upd_idx] <= 1'b1;
                tag_q[upd_idx]   <= upd_tag;
                tgt_q[upd_idx]   <= upd_target;
                ctr_q[upd_idx]   <= CTR_WT;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_branches <= 32'd0;
            stat_mispred  <= 32'd0;
        end else if (upd_en) begin
            if (stat_branches != 32'hFFFF_FFFF)
                stat_branches <= stat_branches + 32'd1;
            if (mispredict && (stat_mispred != 32'hFFFF_FFFF))
                stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        hit;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    branch_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
        .CLK(CLK), .nRST(nRST), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .hit(hit)
`ifdef BP_STATS_EN
        , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a table of branch records keyed by (pc/4) mod ENTRIES,
    // direction held as an integer confidence 0..3.
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_branches;
    logic [31:0] m_mispred;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
    endfunction

    function automatic bit m_ptaken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptarget(input logic [31:0] pc);
        return m_ptaken(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_misp();
        if (!upd_en) return 1'b0;
        return (upd_taken != upd_pred_taken) || (upd_taken && (upd_target != upd_pred_target));
    endfunction

    function automatic logic [31:0] m_redirect();
        if (!upd_en) return 32'd0;
        return upd_taken ? upd_target : upd_pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int e = 0; e < ENTRIES; e++) begin
            m_valid[e] = 1'b0;
            m_tag[e]   = 32'd0;
            m_tgt[e]   = 32'd0;
            m_ctr[e]   = 1;
        end
        m_branches = 32'd0;
        m_mispred  = 32'd0;
    endtask

    // Call right after the rising edge, while the upd_* inputs still hold.
    task automatic model_update();
        int i;
        if (upd_en) begin
            i = m_idx(upd_pc);
            if (m_misp() && m_mispred != 32'hFFFF_FFFF) m_mispred = m_mispred + 1;
            if (m_branches != 32'hFFFF_FFFF) m_branches = m_branches + 1;
            if (m_hit(upd_pc)) begin
                if (upd_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = upd_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = m_tagof(upd_pc);
                m_tgt[i]   = upd_target;
                m_ctr[i]   = 2;
            end
        end
    endtask

    task automatic set_upd(input logic en, input logic [31:0] pc, input logic t,
                           input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        upd_en = en; upd_pc = pc; upd_taken = t;
        upd_target = tgt; upd_pred_taken = pt; upd_pred_target = ptgt;
    endtask

    // One update cycle: drive at the falling edge, let the model follow the rising edge.
    task automatic do_update(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                             input logic pt, input logic [31:0] ptgt);
        @(negedge CLK);
        set_upd(1'b1, pc, t, tgt, pt, ptgt);
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        set_upd(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        fetch_pc = 32'h40;
        set_upd(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        model_reset();
        repeat (2) @(negedge CLK);
        #1;
        n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL reset_hit got %0b want 0", hit); end
        n_cmp++; if (pred_taken !== 1'b0) begin n_bad++; $display("FAIL reset_pred_taken got %0b want 0", pred_taken); end
        n_cmp++; if (pred_target !== 32'h44) begin n_bad++; $display("FAIL reset_pred_target got %h want 00000044", pred_target); end
        n_cmp++; if (mispredict !== 1'b0 || redirect_pc !== 32'd0) begin
            n_bad++; $display("FAIL reset_idle_upd got mp=%0b rd=%h want 0/0", mispredict, redirect_pc);
        end
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        n_cmp++; if (hit !== 1'b0 || pred_target !== 32'h44) begin
            n_bad++; $display("FAIL post_reset_lookup got hit=%0b tgt=%h want 0/00000044", hit, pred_target);
        end
`ifdef BP_STATS_EN
        n_cmp++; if (stat_branches !== 32'd0 || stat_mispred !== 32'd0) begin
            n_bad++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat_branches, stat_mispred);
        end
`endif
    endtask

    task automatic test_allocate();
        @(negedge CLK);
        fetch_pc = 32'h40;
        set_upd(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
        #1;
        n_cmp++; if (mispredict !== 1'b1) begin n_bad++; $display("FAIL alloc_mispredict got %0b want 1", mispredict); end
        n_cmp++; if (redirect_pc !== 32'h80) begin n_bad++; $display("FAIL alloc_redirect got %h want 00000080", redirect_pc); end
        n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL alloc_no_bypass got hit=%0b want 0", hit); end
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        set_upd(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        #1;
        n_cmp++; if (hit !== 1'b1 || pred_taken !== 1'b1) begin
            n_bad++; $display("FAIL alloc_lookup got hit=%0b pt=%0b want 1/1", hit, pred_taken);
        end
        n_cmp++; if (pred_target !== 32'h80) begin n_bad++; $display("FAIL alloc_target got %h want 00000080", pred_target); end
    endtask

    task automatic test_decrement();
        fetch_pc = 32'h40;
        for (int k = 0; k < 4; k++) begin
            do_update(32'h40, 1'b0, 32'h0, m_ptaken(32'h40), m_ptarget(32'h40));
            #1;
            n_cmp++; if (hit !== 1'b1 || pred_taken !== 1'b0) begin
                n_bad++; $display("FAIL dec_%0d got hit=%0b pt=%0b want 1/0", k, hit, pred_taken);
            end
            n_cmp++; if (pred_target !== 32'h44) begin n_bad++; $display("FAIL dec_tgt_%0d got %h want 00000044", k, pred_target); end
        end
        // Counter floored at SNT: one taken step reaches WNT (still not taken), a second reaches WT.
        do_update(32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_bad++; $display("FAIL dec_floor got pt=%0b want 0", pred_taken); end
        do_update(32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
        #1;
        n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
            n_bad++; $display("FAIL dec_recover got pt=%0b tgt=%h want 1/00000080", pred_taken, pred_target);
        end
    endtask

    task automatic test_alias();
        do_update(32'h80, 1'b1, 32'hC0, 1'b0, 32'h84);
        fetch_pc = 32'h40;
        #1;
        n_cmp++; if (hit !== 1'b0 || pred_target !== 32'h44) begin
            n_bad++; $display("FAIL alias_old got hit=%0b tgt=%h want 0/00000044", hit, pred_target);
        end
        fetch_pc = 32'h80;
        #1;
        n_cmp++; if (hit !== 1'b1 || pred_target !== 32'hC0) begin
            n_bad++; $display("FAIL alias_new got hit=%0b tgt=%h want 1/000000c0", hit, pred_target);
        end
    endtask

    task automatic test_target_mispredict();
        @(negedge CLK);
        set_upd(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h90);
        #1;
        n_cmp++; if (mispredict !== 1'b1 || redirect_pc !== 32'h80) begin
            n_bad++; $display("FAIL tgt_misp got mp=%0b rd=%h want 1/00000080", mispredict, redirect_pc);
        end
        set_upd(1'b1, 32'h80, 1'b0, 32'h80, 1'b0, 32'h84);
        #1;
        n_cmp++; if (mispredict !== 1'b0 || redirect_pc !== 32'h84) begin
            n_bad++; $display("FAIL nt_correct got mp=%0b rd=%h want 0/00000084", mispredict, redirect_pc);
        end
        set_upd(1'b1, 32'h80, 1'b0, 32'h80, 1'b1, 32'h80);
        #1;
        n_cmp++; if (mispredict !== 1'b1 || redirect_pc !== 32'h84) begin
            n_bad++; $display("FAIL nt_mispred got mp=%0b rd=%h want 1/00000084", mispredict, redirect_pc);
        end
        set_upd(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic test_wrap_same_cycle();
        @(negedge CLK);
        fetch_pc = 32'hFFFF_FFFC;
        set_upd(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h100, 1'b0, 32'h0);
        #1;
        n_cmp++; if (hit !== 1'b0 || pred_target !== 32'h0) begin
            n_bad++; $display("FAIL wrap_miss got hit=%0b tgt=%h want 0/00000000", hit, pred_target);
        end
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        set_upd(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h100);
        #1;
        n_cmp++; if (hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h100) begin
            n_bad++; $display("FAIL same_cycle_old got hit=%0b pt=%0b tgt=%h want 1/1/00000100", hit, pred_taken, pred_target);
        end
        n_cmp++; if (redirect_pc !== 32'h0 || mispredict !== 1'b1) begin
            n_bad++; $display("FAIL wrap_redirect got mp=%0b rd=%h want 1/00000000", mispredict, redirect_pc);
        end
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        set_upd(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        #1;
        n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
            n_bad++; $display("FAIL same_cycle_new got pt=%0b tgt=%h want 0/00000000", pred_taken, pred_target);
        end
    endtask

    task automatic test_random();
        logic [31:0] pc;
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            fetch_pc = 32'h1000 + 4 * $urandom_range(0, 47);
            pc = 32'h1000 + 4 * $urandom_range(0, 47);
            if ($urandom_range(0, 9) < 7) begin
                if ($urandom_range(0, 1) == 1)
                    set_upd(1'b1, pc, 1'($urandom), 32'h2000 + 4 * $urandom_range(0, 7),
                            m_ptaken(pc), m_ptarget(pc));
                else
                    set_upd(1'b1, pc, 1'($urandom), 32'h2000 + 4 * $urandom_range(0, 7),
                            1'($urandom), 32'h2000 + 4 * $urandom_range(0, 7));
            end else begin
                set_upd(1'b0, pc, 1'($urandom), 32'h2000, 1'($urandom), 32'h2004);
            end
            #1;
            n_cmp++; if (hit !== m_hit(fetch_pc)) begin
                n_bad++; $display("FAIL rnd_hit cyc %0d pc %h got %0b want %0b", c, fetch_pc, hit, m_hit(fetch_pc));
            end
            n_cmp++; if (pred_taken !== m_ptaken(fetch_pc)) begin
                n_bad++; $display("FAIL rnd_pt cyc %0d pc %h got %0b want %0b", c, fetch_pc, pred_taken, m_ptaken(fetch_pc));
            end
            n_cmp++; if (pred_target !== m_ptarget(fetch_pc)) begin
                n_bad++; $display("FAIL rnd_tgt cyc %0d pc %h got %h want %h", c, fetch_pc, pred_target, m_ptarget(fetch_pc));
            end
            n_cmp++; if (mispredict !== m_misp()) begin
                n_bad++; $display("FAIL rnd_mp cyc %0d got %0b want %0b", c, mispredict, m_misp());
            end
            n_cmp++; if (redirect_pc !== m_redirect()) begin
                n_bad++; $display("FAIL rnd_rd cyc %0d got %h want %h", c, redirect_pc, m_redirect());
            end
            @(posedge CLK);
            model_update();
        end
        @(negedge CLK);
        set_upd(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
`ifdef BP_STATS_EN
        #1;
        n_cmp++; if (stat_branches !== m_branches || stat_mispred !== m_mispred) begin
            n_bad++; $display("FAIL rnd_stats got %0d/%0d want %0d/%0d", stat_branches, stat_mispred, m_branches, m_mispred);
        end
`endif
    endtask

    task automatic test_mid_update_reset();
        @(negedge CLK);
        fetch_pc = 32'h300;
        set_upd(1'b1, 32'h300, 1'b1, 32'h400, 1'b0, 32'h304);
        #2;
        nRST = 1'b0;
        @(posedge CLK);
        model_reset();
        @(negedge CLK);
        set_upd(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        nRST = 1'b1;
        #1;
        n_cmp++; if (hit !== 1'b0 || pred_target !== 32'h304) begin
            n_bad++; $display("FAIL midreset_discard got hit=%0b tgt=%h want 0/00000304", hit, pred_target);
        end
        fetch_pc = 32'h80;
        #1;
        n_cmp++; if (hit !== 1'b0 || pred_taken !== 1'b0) begin
            n_bad++; $display("FAIL midreset_clear got hit=%0b pt=%0b want 0/0", hit, pred_taken);
        end
    endtask

`ifdef BP_STATS_EN
    task automatic test_stats();
        for (int k = 0; k < 10; k++) begin
            if (k % 3 == 0 && k < 9)
                do_update(32'h500 + 4 * k, 1'b1, 32'h600, 1'b0, 32'h504 + 4 * k);
            else
                do_update(32'h500 + 4 * k, 1'b0, 32'h600, 1'b0, 32'h504 + 4 * k);
        end
        #1;
        n_cmp++; if (stat_branches !== 32'd10) begin n_bad++; $display("FAIL stat_branches got %0d want 10", stat_branches); end
        n_cmp++; if (stat_mispred !== 32'd3) begin n_bad++; $display("FAIL stat_mispred got %0d want 3", stat_mispred); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_allocate();
        test_decrement();
        test_alias();
        test_target_mispredict();
        test_wrap_same_cycle();
        test_random();
        test_mid_update_reset();
`ifdef BP_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
